// File: rtl/ecc_pkg.sv
// Shared ECC sizing helpers and the scrubber state encoding.
// Hamming code with parity at power-of-two positions and no overall parity bit.
package ecc_pkg;

    typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} scrub_state_e;

    function automatic int unsigned get_parity_width(input int unsigned data_width);
        int unsigned p;
        p = 0;
        while ((32'd1 << p) < (data_width + p + 32'd1)) begin
            p++;
        end
        return p;
    endfunction

    function automatic int unsigned get_cw_width(input int unsigned data_width);
        return data_width + get_parity_width(data_width);
    endfunction

endpackage

// File: rtl/ecc_hamming_decode.sv
// Combinational Hamming decoder: syndrome is the XOR of the 1-based indices of all set bits.
// Syndromes beyond the codeword length cannot name a bit and are reported as uncorrectable.
module ecc_hamming_decode import ecc_pkg::*; #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CwWidth   = get_cw_width(DataWidth),
    parameter int unsigned SynWidth  = get_parity_width(DataWidth)
) (
    input  logic [CwWidth-1:0]  cw_i,
    output logic [CwWidth-1:0]  cw_o,
    output logic [SynWidth-1:0] syndrome_o,
    output logic                single_error_o,
    output logic                uncorrectable_o
);

    always_comb begin
        syndrome_o = '0;
        for (int unsigned i = 0; i < CwWidth; i++) begin
            if (cw_i[i]) begin
                syndrome_o = syndrome_o ^ SynWidth'(i + 1);
            end
        end
    end

    assign single_error_o  = (syndrome_o != '0) && (32'(syndrome_o) <= CwWidth);
    assign uncorrectable_o = (32'(syndrome_o) > CwWidth);

    always_comb begin
        cw_o = cw_i;
        for (int unsigned i = 0; i < CwWidth; i++) begin
            if (single_error_o && (32'(syndrome_o) == i + 1)) begin
                cw_o[i] = ~cw_i[i];
            end
        end
    end

endmodule

// File: rtl/ecc_scrubber.sv
// Background scrubber for one ECC-protected SRAM bank; foreground traffic always wins the bank,
// the scrubber only reads/writes back in otherwise idle cycles.
module ecc_scrubber import ecc_pkg::*; #(
    parameter int unsigned BankSize  = 256,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned AddrWidth = $clog2(BankSize),
    parameter int unsigned CwWidth   = get_cw_width(DataWidth),
    parameter int unsigned SynWidth  = get_parity_width(DataWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 scrub_trigger_i,
    output logic                 busy_o,
    input  logic                 intc_req_i,
    input  logic                 intc_we_i,
    input  logic [AddrWidth-1:0] intc_add_i,
    input  logic [CwWidth-1:0]   intc_wdata_i,
    output logic                 intc_gnt_o,
    output logic [CwWidth-1:0]   intc_rdata_o,
    output logic                 intc_rvalid_o,
    output logic                 bank_req_o,
    output logic                 bank_we_o,
    output logic [AddrWidth-1:0] bank_add_o,
    output logic [CwWidth-1:0]   bank_wdata_o,
    input  logic [CwWidth-1:0]   bank_rdata_i,
    output logic [CntWidth-1:0]  nr_corrected_o,
    output logic [CntWidth-1:0]  nr_uncorrectable_o
);

    scrub_state_e         state_q, state_d;
    logic [AddrWidth-1:0] scrub_addr_q, scrub_addr_d, scrub_addr_next;
    logic [CwWidth-1:0]   corr_q, corr_d;
    logic [CntWidth-1:0]  ncor_q, ncor_d, nunc_q, nunc_d;
    logic                 rvalid_q;
    logic                 scrub_req, scrub_we;

    logic [CwWidth-1:0]   dec_cw;
    logic [SynWidth-1:0]  dec_syndrome;
    logic                 dec_single, dec_uncorr;

    ecc_hamming_decode #(
        .DataWidth (DataWidth),
        .CwWidth   (CwWidth),
        .SynWidth  (SynWidth)
    ) u_decode (
        .cw_i            (bank_rdata_i),
        .cw_o            (dec_cw),
        .syndrome_o      (dec_syndrome),
        .single_error_o  (dec_single),
        .uncorrectable_o (dec_uncorr)
    );

    assign scrub_addr_next = (scrub_addr_q == AddrWidth'(BankSize - 1)) ? '0
                           : scrub_addr_q + AddrWidth'(1);

    always_comb begin
        state_d      = state_q;
        scrub_addr_d = scrub_addr_q;
        corr_d       = corr_q;
        ncor_d       = ncor_q;
        nunc_d       = nunc_q;
        scrub_req    = 1'b0;
        scrub_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scrub_trigger_i) state_d = READ;
            end
            READ: begin
                if (!intc_req_i) begin
                    scrub_req = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // The read already went out last cycle, so foreground traffic now is harmless.
                if (dec_syndrome == '0) begin
                    scrub_addr_d = scrub_addr_next;
                    state_d      = IDLE;
                end else if (dec_single) begin
                    corr_d  = dec_cw;
                    state_d = WRITE;
                end else if (dec_uncorr) begin
                    if (~&nunc_q) nunc_d = nunc_q + CntWidth'(1);
                    scrub_addr_d = scrub_addr_next;
                    state_d      = IDLE;
                end
            end
            WRITE: begin
                if (!intc_req_i) begin
                    scrub_req    = 1'b1;
                    scrub_we     = 1'b1;
                    if (~&ncor_q) ncor_d = ncor_q + CntWidth'(1);
                    scrub_addr_d = scrub_addr_next;
                    state_d      = IDLE;
                end else if (intc_we_i && (intc_add_i == scrub_addr_q)) begin
                    // Foreground just overwrote this entry; our corrected copy is stale.
                    scrub_addr_d = scrub_addr_next;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_add_o   = '0;
        bank_wdata_o = '0;
        if (rst_i) begin
            bank_req_o = 1'b0;
        end else if (intc_req_i) begin
            bank_req_o   = 1'b1;
            bank_we_o    = intc_we_i;
            bank_add_o   = intc_add_i;
            bank_wdata_o = intc_wdata_i;
        end else if (scrub_req) begin
            bank_req_o   = 1'b1;
            bank_we_o    = scrub_we;
            bank_add_o   = scrub_addr_q;
            bank_wdata_o = corr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            scrub_addr_q <= '0;
            corr_q       <= '0;
            ncor_q       <= '0;
            nunc_q       <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            scrub_addr_q <= scrub_addr_d;
            corr_q       <= corr_d;
            ncor_q       <= ncor_d;
            nunc_q       <= nunc_d;
            rvalid_q     <= intc_req_i & ~intc_we_i;
        end
    end

    assign busy_o             = (state_q != IDLE);
    assign intc_gnt_o         = intc_req_i;
    assign intc_rdata_o       = bank_rdata_i;
    assign intc_rvalid_o      = rvalid_q;
    assign nr_corrected_o     = ncor_q;
    assign nr_uncorrectable_o = nunc_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Self-checking bench for ecc_scrubber: 8-entry bank model, 2-bit counters to reach saturation.
module tb_ecc_scrubber;

    localparam int BankSize  = 8;
    localparam int DataWidth = 32;
    localparam int CntWidth  = 2;
    localparam int AW        = 3;
    localparam int CW        = 38;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          scrub_trigger_i = 1'b0;
    logic          intc_req_i = 1'b0;
    logic          intc_we_i = 1'b0;
    logic [AW-1:0] intc_add_i = '0;
    logic [CW-1:0] intc_wdata_i = '0;
    logic          busy_o, intc_gnt_o, intc_rvalid_o, bank_req_o, bank_we_o;
    logic [CW-1:0] intc_rdata_o, bank_wdata_o;
    logic [AW-1:0] bank_add_o;
    logic [CW-1:0] bank_rdata_q = '0;
    logic [CntWidth-1:0] nr_corrected_o, nr_uncorrectable_o;

    logic [CW-1:0] mem [BankSize];

    typedef struct {
        int            addr;
        logic [CW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    logic [CW-1:0] exp_rd[$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    ecc_scrubber #(
        .BankSize  (BankSize),
        .DataWidth (DataWidth),
        .CntWidth  (CntWidth)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .scrub_trigger_i    (scrub_trigger_i),
        .busy_o             (busy_o),
        .intc_req_i         (intc_req_i),
        .intc_we_i          (intc_we_i),
        .intc_add_i         (intc_add_i),
        .intc_wdata_i       (intc_wdata_i),
        .intc_gnt_o         (intc_gnt_o),
        .intc_rdata_o       (intc_rdata_o),
        .intc_rvalid_o      (intc_rvalid_o),
        .bank_req_o         (bank_req_o),
        .bank_we_o          (bank_we_o),
        .bank_add_o         (bank_add_o),
        .bank_wdata_o       (bank_wdata_o),
        .bank_rdata_i       (bank_rdata_q),
        .nr_corrected_o     (nr_corrected_o),
        .nr_uncorrectable_o (nr_uncorrectable_o)
    );

    always @(posedge clk) begin
        if (bank_req_o) begin
            if (bank_we_o) mem[bank_add_o] = bank_wdata_o;
            else           bank_rdata_q <= mem[bank_add_o];
        end
    end

    // Scoreboard: foreground read data and scrub writebacks.
    always @(negedge clk) begin
        if (intc_rvalid_o) begin
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL rvalid_spurious got rvalid=1 exp rvalid=0");
            end else begin
                logic [CW-1:0] e;
                e = exp_rd.pop_front();
                if (intc_rdata_o !== e) begin
                    errors++;
                    $display("FAIL fg_rdata got %h exp %h", intc_rdata_o, e);
                end
            end
        end
        if (!rst_i && intc_req_i && !intc_we_i) exp_rd.push_back(mem[intc_add_i]);
        if (bank_req_o && bank_we_o && !intc_req_i) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL scrub_write_spurious got addr=%0d data=%h exp none",
                         bank_add_o, bank_wdata_o);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                if (int'(bank_add_o) != w.addr || bank_wdata_o !== w.data) begin
                    errors++;
                    $display("FAIL scrub_write got addr=%0d data=%h exp addr=%0d data=%h",
                             bank_add_o, bank_wdata_o, w.addr, w.data);
                end
            end
        end
    end

    function automatic logic [CW-1:0] enc(input logic [31:0] d);
        logic [CW-1:0] cw;
        logic          par;
        int            j;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos <= CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[j];
                j++;
            end
        end
        for (int p = 0; p < 6; p++) begin
            par = 1'b0;
            for (int pos = 1; pos <= CW; pos++) begin
                if (((pos >> p) & 1) == 1) par = par ^ cw[pos-1];
            end
            cw[(1 << p) - 1] = par;
        end
        return cw;
    endfunction

    function automatic logic [31:0] data_of(input int i);
        return 32'hA5C3_0000 + 32'(i) * 32'h0101_1357;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        scrub_trigger_i = 1'b0;
        intc_req_i = 1'b0;
        intc_we_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic load_clean();
        for (int i = 0; i < BankSize; i++) mem[i] = enc(data_of(i));
    endtask

    task automatic push_wr(input int a, input logic [CW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic do_scrub(output int rd_addr, output int rd_at, output int busy_n,
                            output int wr_at);
        rd_addr = -1;
        rd_at   = -1;
        busy_n  = 0;
        wr_at   = -1;
        scrub_trigger_i = 1'b1;
        tick();
        scrub_trigger_i = 1'b0;
        for (int i = 0; i < 40 && busy_o; i++) begin
            if (bank_req_o && !intc_req_i && !bank_we_o) begin
                rd_addr = int'(bank_add_o);
                rd_at   = i;
            end
            if (bank_req_o && !intc_req_i && bank_we_o) wr_at = i;
            busy_n++;
            tick();
        end
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL scrub_timeout got busy=1 exp busy=0 within 40 cycles");
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 5;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
        if (intc_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL rst_rvalid got %b exp 0", intc_rvalid_o);
        end
        if (bank_req_o !== 1'b0 || bank_we_o !== 1'b0) begin
            errors++; $display("FAIL rst_bank got req=%b we=%b exp 0 0", bank_req_o, bank_we_o);
        end
        if (nr_corrected_o !== '0) begin
            errors++; $display("FAIL rst_ncor got %0d exp 0", nr_corrected_o);
        end
        if (nr_uncorrectable_o !== '0) begin
            errors++; $display("FAIL rst_nunc got %0d exp 0", nr_uncorrectable_o);
        end
    endtask

    task automatic test_clean_scrub();
        int a, at, bn, wa;
        apply_reset();
        load_clean();
        do_scrub(a, at, bn, wa);
        checks += 5;
        if (a != 0 || at != 0) begin
            errors++; $display("FAIL clean_read got addr=%0d at=%0d exp addr=0 at=0", a, at);
        end
        if (bn != 2) begin errors++; $display("FAIL clean_busy got %0d exp 2", bn); end
        if (wa != -1) begin errors++; $display("FAIL clean_nowrite got at=%0d exp -1", wa); end
        if (nr_corrected_o !== '0 || nr_uncorrectable_o !== '0) begin
            errors++;
            $display("FAIL clean_cnt got %0d/%0d exp 0/0", nr_corrected_o, nr_uncorrectable_o);
        end
        do_scrub(a, at, bn, wa);
        if (a != 1) begin errors++; $display("FAIL clean_addr_adv got %0d exp 1", a); end
    endtask

    task automatic test_single_error();
        int a, at, bn, wa;
        apply_reset();
        load_clean();
        mem[3] = mem[3] ^ (38'd1 << 5);
        for (int i = 0; i < 3; i++) do_scrub(a, at, bn, wa);
        push_wr(3, enc(data_of(3)));
        do_scrub(a, at, bn, wa);
        checks += 4;
        if (a != 3) begin errors++; $display("FAIL single_read got %0d exp 3", a); end
        if (wa != 2 || bn != 3) begin
            errors++; $display("FAIL single_timing got wr_at=%0d busy=%0d exp 2 3", wa, bn);
        end
        if (nr_corrected_o !== 2'd1 || nr_uncorrectable_o !== 2'd0) begin
            errors++;
            $display("FAIL single_cnt got %0d/%0d exp 1/0", nr_corrected_o, nr_uncorrectable_o);
        end
        if (mem[3] !== enc(data_of(3))) begin
            errors++; $display("FAIL single_mem got %h exp %h", mem[3], enc(data_of(3)));
        end
    endtask

    task automatic test_uncorrectable();
        int a, at, bn, wa;
        apply_reset();
        load_clean();
        mem[2] = mem[2] ^ (38'd1 << 7) ^ (38'd1 << 31);
        for (int i = 0; i < 2; i++) do_scrub(a, at, bn, wa);
        do_scrub(a, at, bn, wa);
        checks += 3;
        if (a != 2 || wa != -1) begin
            errors++; $display("FAIL uncorr_read got addr=%0d wr_at=%0d exp 2 -1", a, wa);
        end
        if (nr_uncorrectable_o !== 2'd1 || nr_corrected_o !== 2'd0) begin
            errors++;
            $display("FAIL uncorr_cnt got %0d/%0d exp 0/1", nr_corrected_o, nr_uncorrectable_o);
        end
        do_scrub(a, at, bn, wa);
        if (a != 3) begin errors++; $display("FAIL uncorr_addr_adv got %0d exp 3", a); end
    endtask

    task automatic test_fg_priority();
        apply_reset();
        load_clean();
        scrub_trigger_i = 1'b1;
        tick();
        scrub_trigger_i = 1'b0;
        intc_req_i = 1'b1;
        intc_we_i  = 1'b0;
        intc_add_i = 3'd5;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (intc_gnt_o !== 1'b1 || bank_add_o !== 3'd5 || bank_we_o !== 1'b0) begin
                errors++;
                $display("FAIL fg_mirror got gnt=%b add=%0d we=%b exp 1 5 0",
                         intc_gnt_o, bank_add_o, bank_we_o);
            end
            tick();
        end
        intc_req_i = 1'b0;
        #1;
        checks++;
        if (!(busy_o && bank_req_o && !bank_we_o && bank_add_o == 3'd0)) begin
            errors++;
            $display("FAIL fg_scrub_read got busy=%b req=%b add=%0d exp 1 1 0",
                     busy_o, bank_req_o, bank_add_o);
        end
        tick();
        checks++;
        if (intc_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL fg_scrub_rvalid got %b exp 0", intc_rvalid_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL fg_done got busy=%b exp 0", busy_o); end
    endtask

    task automatic test_collision();
        int a, at, bn, wa;
        logic [CW-1:0] w5, w1;
        w5 = enc(32'h5555_AAAA);
        w1 = enc(32'h1234_5678);
        apply_reset();
        load_clean();
        mem[0] = mem[0] ^ (38'd1 << 10);
        mem[1] = mem[1] ^ (38'd1 << 20);
        scrub_trigger_i = 1'b1;
        tick();
        scrub_trigger_i = 1'b0;
        tick();
        tick();
        // In WRITE: a foreground write elsewhere stalls the writeback
        intc_req_i = 1'b1; intc_we_i = 1'b1; intc_add_i = 3'd5; intc_wdata_i = w5;
        tick();
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL stall_busy got %b exp 1", busy_o); end
        intc_req_i = 1'b0; intc_we_i = 1'b0;
        push_wr(0, enc(data_of(0)));
        tick();
        checks += 2;
        if (nr_corrected_o !== 2'd1) begin
            errors++; $display("FAIL stall_ncor got %0d exp 1", nr_corrected_o);
        end
        if (mem[5] !== w5) begin errors++; $display("FAIL stall_fgmem got %h exp %h", mem[5], w5); end
        scrub_trigger_i = 1'b1;
        tick();
        scrub_trigger_i = 1'b0;
        tick();
        tick();
        intc_req_i = 1'b1; intc_we_i = 1'b1; intc_add_i = 3'd1; intc_wdata_i = w1;
        tick();
        intc_req_i = 1'b0; intc_we_i = 1'b0;
        checks += 3;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL coll_busy got %b exp 0", busy_o); end
        if (mem[1] !== w1) begin errors++; $display("FAIL coll_mem got %h exp %h", mem[1], w1); end
        if (nr_corrected_o !== 2'd1) begin
            errors++; $display("FAIL coll_ncor got %0d exp 1", nr_corrected_o);
        end
        do_scrub(a, at, bn, wa);
        checks++;
        if (a != 2) begin errors++; $display("FAIL coll_addr_adv got %0d exp 2", a); end
    endtask

    task automatic test_wrap();
        int a, at, bn, wa;
        apply_reset();
        load_clean();
        for (int i = 0; i <= BankSize; i++) begin
            do_scrub(a, at, bn, wa);
            checks++;
            if (a != (i % BankSize)) begin
                errors++; $display("FAIL wrap_addr got %0d exp %0d", a, i % BankSize);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int a, at, bn, wa;
        logic [CW-1:0] bad;
        apply_reset();
        load_clean();
        mem[1] = mem[1] ^ (38'd1 << 3);
        bad = mem[1];
        do_scrub(a, at, bn, wa);
        scrub_trigger_i = 1'b1;
        tick();
        scrub_trigger_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if (bank_req_o !== 1'b0 || bank_we_o !== 1'b0) begin
            errors++; $display("FAIL rstw_bank got req=%b we=%b exp 0 0", bank_req_o, bank_we_o);
        end
        tick();
        rst_i = 1'b0;
        checks += 3;
        if (busy_o !== 1'b0 || intc_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL rstw_state got busy=%b rvalid=%b exp 0 0", busy_o, intc_rvalid_o);
        end
        if (nr_corrected_o !== '0) begin
            errors++; $display("FAIL rstw_ncor got %0d exp 0", nr_corrected_o);
        end
        if (mem[1] !== bad) begin errors++; $display("FAIL rstw_mem got %h exp %h", mem[1], bad); end
        do_scrub(a, at, bn, wa);
        checks++;
        if (a != 0) begin errors++; $display("FAIL rstw_addr got %0d exp 0", a); end
    endtask

    task automatic test_saturation();
        int a, at, bn, wa;
        apply_reset();
        load_clean();
        for (int i = 0; i < BankSize; i++) mem[i] = mem[i] ^ (38'd1 << (i + 1));
        for (int i = 0; i < 5; i++) begin
            push_wr(i, enc(data_of(i)));
            do_scrub(a, at, bn, wa);
        end
        checks++;
        if (nr_corrected_o !== 2'd3) begin
            errors++; $display("FAIL sat_ncor got %0d exp 3", nr_corrected_o);
        end
    endtask

    initial begin
        test_reset();
        test_clean_scrub();
        test_single_error();
        test_uncorrectable();
        test_fg_priority();
        test_collision();
        test_wrap();
        test_reset_mid_write();
        test_saturation();
        tick();
        tick();
        checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got wr=%0d rd=%0d exp 0 0", exp_wr.size(), exp_rd.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
